iob_timer_reader: RTL and testbench

IOB_TIMER_READER -- requirements
Module: iob_timer_reader

---
 rtl/iob_timer_reader_pkg.sv | 34 +++
 rtl/iob_timer_reader_if.sv | 24 ++
 rtl/iob_timer_reader_acc.sv | 93 +++++++++
 rtl/iob_timer_reader.sv | 167 ++++++++++++++++
 tb/tb_iob_timer_reader.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iob_timer_reader_pkg.sv
// Shared encodings and default register map for iob_timer_reader.
// The IOB_TIMER_READER_TIMEOUT_EN macro enables the per-access wait counter.
package iob_timer_reader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_SET = 3'd1,
        S_WR_CLR = 3'd2,
        S_RD_LO  = 3'd3,
        S_RD_HI  = 3'd4,
        S_FIN    = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        OP_SAMPLE  = 2'b00,
        OP_ENABLE  = 2'b01,
        OP_DISABLE = 2'b10,
        OP_SRESET  = 2'b11
    } op_e;

    localparam int DEF_RESET_ADDR  = 0;
    localparam int DEF_ENABLE_ADDR = 4;
    localparam int DEF_SAMPLE_ADDR = 8;
    localparam int DEF_LOW_ADDR    = 12;
    localparam int DEF_HIGH_ADDR   = 16;

    // Wait counter is at least 8 bits and always wide enough to reach the timeout.
    function automatic int tmo_cnt_w(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w > 8) ? w : 8;
    endfunction

endpackage

// File: rtl/iob_timer_reader_if.sv
// IOb bus between the timer reader (master) and the timer registers (slave).
// An access is offered while m_valid=1 with all request fields stable and completes
// in the cycle m_valid & m_ready; m_ready seen while m_valid=0 carries no meaning.
interface iob_timer_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic                  m_valid;
    logic [ADDR_W-1:0]     m_address;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W/8-1:0]   m_wstrb;
    logic [DATA_W-1:0]     m_rdata;
    logic                  m_ready;

    modport master (
        output m_valid, m_address, m_wdata, m_wstrb,
        input  m_rdata, m_ready
    );

    modport slave (
        input  m_valid, m_address, m_wdata, m_wstrb,
        output m_rdata, m_ready
    );
endinterface

// File: rtl/iob_timer_reader_acc.sv
// Single IOb access engine: registers the request, holds it until ready and,
// with IOB_TIMER_READER_TIMEOUT_EN defined, abandons it after TIMEOUT wait cycles.
module iob_timer_reader_acc
    import iob_timer_reader_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    output logic                ack_o,
    output logic                timeout_o,
    output logic                pend_o,
    output logic [DATA_W-1:0]   rdata_o,
    iob_timer_reader_if.master  bus
);

    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                tmo;

    assign ack_o = valid_q & bus.m_ready;

`ifdef IOB_TIMER_READER_TIMEOUT_EN
    localparam int CNT_W = tmo_cnt_w(TIMEOUT);

    logic [CNT_W-1:0] wait_q;
    logic             stall;

    assign stall = valid_q & ~bus.m_ready;
    assign tmo   = stall & (wait_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else if (stall && !tmo) begin
            wait_q <= wait_q + CNT_W'(1);
        end else begin
            wait_q <= '0;
        end
    end
`else
    logic unused_timeout;

    assign tmo            = 1'b0;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        if (req_i) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
            wdata_d = wdata_i;
            wstrb_d = wstrb_i;
        end else if (ack_o || tmo) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign bus.m_valid   = valid_q;
    assign bus.m_address = addr_q;
    assign bus.m_wdata   = wdata_q;
    assign bus.m_wstrb   = wstrb_q;
    assign timeout_o     = tmo;
    assign pend_o        = valid_q;
    assign rdata_o       = bus.m_rdata;

endmodule

// File: rtl/iob_timer_reader.sv
// Command FSM that samples, enables, disables or soft-resets an IOb timer.
// IOB_TIMER_READER_TIMEOUT_EN adds a sticky error flag fed by the access timeout.
module iob_timer_reader
    import iob_timer_reader_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int RESET_ADDR  = DEF_RESET_ADDR,
    parameter int ENABLE_ADDR = DEF_ENABLE_ADDR,
    parameter int SAMPLE_ADDR = DEF_SAMPLE_ADDR,
    parameter int LOW_ADDR    = DEF_LOW_ADDR,
    parameter int HIGH_ADDR   = DEF_HIGH_ADDR,
    parameter int TIMEOUT     = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   value,
    output logic                  error,
    output state_e                dbg_state_o,
    iob_timer_reader_if.master    bus
);

    localparam logic [DATA_W/8-1:0] STRB_ALL = '1;

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [DATA_W-1:0]   low_q, low_d;
    logic [2*DATA_W-1:0] value_q, value_d;
    logic                err_set, err_clr;

    logic                req;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [DATA_W/8-1:0] req_wstrb;
    logic                acc_ack, acc_tmo, acc_pend;
    logic [DATA_W-1:0]   acc_rdata;

    iob_timer_reader_acc #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req),
        .addr_i    (req_addr),
        .wdata_i   (req_wdata),
        .wstrb_i   (req_wstrb),
        .ack_o     (acc_ack),
        .timeout_o (acc_tmo),
        .pend_o    (acc_pend),
        .rdata_o   (acc_rdata),
        .bus       (bus)
    );

    // Request fields follow the current state; the engine only latches them on req.
    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        unique case (state_q)
            S_WR_SET: begin
                req_wstrb = STRB_ALL;
                req_wdata = (op_q == OP_DISABLE) ? '0 : DATA_W'(1);
                case (op_q)
                    OP_SAMPLE:             req_addr = ADDR_W'(SAMPLE_ADDR);
                    OP_ENABLE, OP_DISABLE: req_addr = ADDR_W'(ENABLE_ADDR);
                    default:               req_addr = ADDR_W'(RESET_ADDR);
                endcase
            end
            S_WR_CLR: begin
                req_wstrb = STRB_ALL;
                req_addr  = (op_q == OP_SAMPLE) ? ADDR_W'(SAMPLE_ADDR) : ADDR_W'(RESET_ADDR);
            end
            S_RD_LO: req_addr = ADDR_W'(LOW_ADDR);
            S_RD_HI: req_addr = ADDR_W'(HIGH_ADDR);
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        low_d   = low_q;
        value_d = value_q;
        err_set = 1'b0;
        err_clr = 1'b0;
        req     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op_e'(op);
                    err_clr = 1'b1;
                    state_d = S_WR_SET;
                end
            end
            S_FIN: state_d = S_IDLE;
            default: begin
                // Idle engine in an access state means the previous access just retired.
                req = ~acc_pend;
                if (acc_tmo) begin
                    err_set = 1'b1;
                    state_d = S_FIN;
                end else if (acc_ack) begin
                    case (state_q)
                        S_WR_SET: state_d = (op_q == OP_SAMPLE || op_q == OP_SRESET) ? S_WR_CLR : S_FIN;
                        S_WR_CLR: state_d = (op_q == OP_SAMPLE) ? S_RD_LO : S_FIN;
                        S_RD_LO: begin
                            low_d   = acc_rdata;
                            state_d = S_RD_HI;
                        end
                        S_RD_HI: begin
                            value_d = {acc_rdata, low_q};
                            state_d = S_FIN;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_SAMPLE;
            low_q   <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            low_q   <= low_d;
            value_q <= value_d;
        end
    end

`ifdef IOB_TIMER_READER_TIMEOUT_EN
    logic error_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_q <= 1'b0;
        end else if (err_clr) begin
            error_q <= 1'b0;
        end else if (err_set) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;
`else
    logic unused_err;

    assign unused_err = err_set ^ err_clr;
    assign error      = 1'b0;
`endif

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FIN);
    assign value       = value_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iob_timer_reader.sv
// Randomized bench for iob_timer_reader: a command-level model predicts the bus
// accesses and sampled value; a slave model with random wait states checks them.
module tb_iob_timer_reader;
    import iob_timer_reader_pkg::*;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int A_RESET  = 0;
    localparam int A_ENABLE = 4;
    localparam int A_SAMPLE = 8;
    localparam int A_LOW    = 12;
    localparam int A_HIGH   = 16;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        busy, done, error;
    logic [63:0] value;
    state_e      dbg_state;

    iob_timer_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    iob_timer_reader #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .busy        (busy),
        .done        (done),
        .value       (value),
        .error       (error),
        .dbg_state_o (dbg_state),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [40:0] exp_q[$];
    logic [63:0] tmr = '0;
    logic [63:0] exp_value = '0;
    int          wait_min = 0;
    int          wait_max = 0;
    bit          stall = 1'b0;
    int          cmd_acc_idx = 0;
    int          last_cmpl_cyc = 0;
    int          cyc = 0;
    bit          prev_valid = 1'b0;
    bit          prev_cmpl = 1'b0;
    int          wait_left = 0;
    logic [40:0] held = '0;
    bit          seen_lo = 1'b0;
    int          valid_cyc_cnt = 0;
    int          done_cnt = 0;
    bit          done_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [40:0] acc_w(input int a, input logic [31:0] d, input logic [3:0] s);
        return {5'(a), d, s};
    endfunction

    task automatic push_model(input logic [1:0] o, output int n);
        case (o)
            2'b00: begin
                exp_q.push_back(acc_w(A_SAMPLE, 32'd1, 4'hF));
                exp_q.push_back(acc_w(A_SAMPLE, 32'd0, 4'hF));
                exp_q.push_back(acc_w(A_LOW, 32'd0, 4'h0));
                exp_q.push_back(acc_w(A_HIGH, 32'd0, 4'h0));
                n = 4;
            end
            2'b01: begin
                exp_q.push_back(acc_w(A_ENABLE, 32'd1, 4'hF));
                n = 1;
            end
            2'b10: begin
                exp_q.push_back(acc_w(A_ENABLE, 32'd0, 4'hF));
                n = 1;
            end
            default: begin
                exp_q.push_back(acc_w(A_RESET, 32'd1, 4'hF));
                exp_q.push_back(acc_w(A_RESET, 32'd0, 4'hF));
                n = 2;
            end
        endcase
    endtask

    // ---------------- slave model / bus monitor ----------------
    always @(negedge clk) begin
        logic [40:0] cur;
        if (!rst_n) begin
            bus.m_ready = 1'b0;
            bus.m_rdata = '0;
            prev_valid  = 1'b0;
            prev_cmpl   = 1'b0;
        end else begin
            cyc++;
            if (bus.m_valid) begin
                valid_cyc_cnt++;
                cur = {bus.m_address, bus.m_wdata, bus.m_wstrb};
                if (!prev_valid || prev_cmpl) begin
                    if (cmd_acc_idx > 0) check("gap", 64'(cyc - last_cmpl_cyc), 2);
                    held      = cur;
                    wait_left = $urandom_range(wait_max, wait_min);
                    if (bus.m_address == 5'(A_LOW)) seen_lo = 1'b1;
                end else begin
                    check("hold", 64'(cur), 64'(held));
                end
                if (!stall && wait_left == 0) begin
                    bus.m_ready = 1'b1;
                    if (bus.m_address == 5'(A_LOW)) bus.m_rdata = tmr[31:0];
                    else if (bus.m_address == 5'(A_HIGH)) bus.m_rdata = tmr[63:32];
                    else bus.m_rdata = $urandom;
                    if (exp_q.size() > 0) check("acc", 64'(cur), 64'(exp_q.pop_front()));
                    cmd_acc_idx++;
                    last_cmpl_cyc = cyc;
                    prev_cmpl     = 1'b1;
                end else begin
                    bus.m_ready = 1'b0;
                    if (wait_left > 0) wait_left--;
                    prev_cmpl = 1'b0;
                end
            end else begin
                bus.m_ready = 1'b0;
                prev_cmpl   = 1'b0;
            end
            prev_valid = bus.m_valid;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                done_cnt++;
                check("done_pulse", 64'(done_prev), 0);
            end
            done_prev = done;
        end else begin
            done_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_cmd(input logic [1:0] o, input logic [63:0] t, input int wmin,
                           input int wmax, input bit poke);
        int n, d0, n_exp;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        wait_min = wmin;
        wait_max = wmax;
        tmr      = t;
        exp_q.delete();
        push_model(o, n_exp);
        if (o == 2'b00) exp_value = t;
        cmd_acc_idx = 0;
        d0 = done_cnt;
        start = 1'b1;
        op    = o;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 2'($urandom);
        check("busy_set", 64'(busy), 1);
        check("error_clr", 64'(error), 0);
        n = 0;
        while (done_cnt == d0 && n < 400) begin
            start = poke && (n == 2) && busy;
            if (start) op = 2'b11;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("done_seen", 64'(done_cnt - d0), 1);
        check("busy_clr", 64'(busy), 0);
        check("value", value, exp_value);
        check("error", 64'(error), 0);
        check("acc_count", 64'(cmd_acc_idx), 64'(n_exp));
        check("acc_left", 64'(exp_q.size()), 0);
        @(posedge clk); #1;
        check("done_once", 64'(done_cnt - d0), 1);
    endtask

    task automatic reset_mid_rd_lo();
        int n, d0, n_exp;
        wait_min = 3;
        wait_max = 3;
        tmr      = {$urandom, $urandom};
        exp_q.delete();
        push_model(2'b00, n_exp);
        cmd_acc_idx = 0;
        seen_lo = 1'b0;
        d0 = done_cnt;
        start = 1'b1;
        op    = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!seen_lo && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("rd_lo_reached", 64'(seen_lo), 1);
        check("rd_lo_state", 64'(dbg_state), 64'(S_RD_LO));
        rst_n = 1'b0;
        #1;
        exp_value = '0;
        check("rst_mid_valid", 64'(bus.m_valid), 0);
        check("rst_mid_busy", 64'(busy), 0);
        check("rst_mid_value", value, exp_value);
        check("rst_mid_done", 64'(done), 0);
        check("rst_mid_state", 64'(dbg_state), 64'(S_IDLE));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_no_done", 64'(done_cnt - d0), 0);
        check("rst_value_kept", value, exp_value);
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_error", 64'(error), 0);
        check("rst_value", value, 0);
        check("rst_valid", 64'(bus.m_valid), 0);
        check("rst_addr", 64'(bus.m_address), 0);
        check("rst_wdata", 64'(bus.m_wdata), 0);
        check("rst_wstrb", 64'(bus.m_wstrb), 0);
        check("rst_state", 64'(dbg_state), 64'(S_IDLE));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", 64'(busy), 0);

        run_cmd(2'b00, 64'h00000001_00000005, 0, 0, 1'b0);
        reset_mid_rd_lo();
        run_cmd(2'b01, {$urandom, $urandom}, 3, 3, 1'b0);
        run_cmd(2'b00, {$urandom, $urandom}, 0, 0, 1'b1);
        run_cmd(2'b11, {$urandom, $urandom}, 0, 2, 1'b0);

`ifdef IOB_TIMER_READER_TIMEOUT_EN
        begin
            int n, d0;
            stall = 1'b1;
            exp_q.delete();
            cmd_acc_idx   = 0;
            valid_cyc_cnt = 0;
            d0 = done_cnt;
            start = 1'b1;
            op    = 2'b01;
            @(posedge clk); #1;
            start = 1'b0;
            n = 0;
            while (done_cnt == d0 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            check("tmo_done", 64'(done_cnt - d0), 1);
            check("tmo_valid_cycles", 64'(valid_cyc_cnt), 4);
            check("tmo_error", 64'(error), 1);
            check("tmo_value", value, exp_value);
            check("tmo_acc", 64'(cmd_acc_idx), 0);
            stall = 1'b0;
            run_cmd(2'b01, {$urandom, $urandom}, 0, 2, 1'b0);
        end
`endif

        for (int i = 0; i < 24; i++) begin
            run_cmd(2'($urandom_range(0, 3)), {$urandom, $urandom}, 0,
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
